// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the multi-port register file.
package reg_file_pkg;

  // Clear-sweep controller states
  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  // Default geometry: RV32 integer register file with two operand ports
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NUM_RD = 2;

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Clear-sweep controller: owns the IDLE/CLEAR state, the sweep counter and
// the registered busy / wr_ready handshake, and tells the array which entry
// to zero on each sweep cycle.
module reg_file_clr_fsm
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_ready,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rf_state_t         r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;
  logic              r_wr_ready;

  // State, counter and handshake outputs all update together on the edge
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    if (!rst) begin
      r_state    <= RF_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_wr_ready <= 1'b1;
    end else begin
      case (r_state)
        RF_IDLE: begin
          if (clr_req) begin
            r_state    <= RF_CLEAR;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b0;
          end
        end
        RF_CLEAR: begin
          // clr_req is deliberately ignored here; the sweep always runs DEPTH cycles
          if (r_cnt == LAST_ADDR) begin
            r_state    <= RF_IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        default: begin
          r_state    <= RF_IDLE;
          r_cnt      <= '0;
          r_busy     <= 1'b0;
          r_wr_ready <= 1'b1;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign wr_ready = r_wr_ready;
  assign clr_en   = (r_state == RF_CLEAR);
  assign clr_addr = r_cnt;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with optional hardwired zero register,
// registered one-cycle reads and a multi-cycle clear sweep.
// Build option: define REGFILE_BYPASS_EN to forward an accepted write to any
// read port addressing the same entry on the same edge.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DEPTH    = 2 ** ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic                     clr_req,
  output logic                     busy
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr_ready;
  logic              w_clr_en;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_en;

  reg_file_clr_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_ready (w_wr_ready),
    .clr_en   (w_clr_en),
    .clr_addr (w_clr_addr)
  );

  assign wr_ready = w_wr_ready;

  // A write lands only when accepted, in range, and not aimed at the zero register
  assign w_wr_en = we && w_wr_ready && (int'(wr_addr) < DEPTH)
                   && !((ZERO_REG != 0) && (wr_addr == '0));

  // Storage update: reset zeroes everything, the sweep zeroes one entry per cycle
  always_ff @(posedge clk) begin
    // NOTE: the array is reset like any other register so that a reset leaves
    // every entry at 0 in the next cycle; this rules out RAM-macro inference.
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_clr_en) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_next;
    logic [DATA_W-1:0] r_data;

    assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];

    // Next read value: zero for the zero register or out-of-range, else array or bypass
    always_comb begin
      // NOTE: w_next gets a default before any condition so no latch is inferred.
      w_next = '0;
      if ((int'(w_addr) < DEPTH) && !((ZERO_REG != 0) && (w_addr == '0))) begin
        w_next = r_mem[w_addr];
        if (BYPASS_EN && w_wr_en && (wr_addr == w_addr)) w_next = wr_data;
      end
    end

    // Registered read port
    always_ff @(posedge clk) begin
      if (!rst) r_data <= '0;
      else      r_data <= w_next;
    end

    assign rd_data[k*DATA_W +: DATA_W] = r_data;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file, the successor to the core's 2-read/1-write register file. It adds configurable data width, depth and read-port count, a hardwired zero register and a registered one-cycle read path. It also adds a multi-cycle clear sweep with a busy/ready handshake and optional write-to-read bypass. It sits in the decode stage of the RISC-V datapath and feeds operands to the ALU and branch unit.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width
- DEPTH, 2**ADDR_W, number of registers; must be ≤ 2**ADDR_W and ≥ 2
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores writes
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0)
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data; port k at bits [k*DATA_W +: DATA_W]
- we  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ready  out  1  write accepted this cycle when we=1
- clr_req  in  1  single-cycle pulse that starts a clear sweep
- busy  out  1  clear sweep in progress

## Operation
- Reset (rst=0 at edge): all DEPTH entries become 0, rd_data becomes 0, FSM goes to IDLE, the sweep counter becomes 0, busy=0 and wr_ready=1 from the next cycle.
- FSM states:
  - IDLE → CLEAR on clr_req=1.
  - CLEAR → IDLE after the entry at DEPTH-1 is cleared.
- IDLE:
  - wr_ready=1 and busy=0.
  - A write with we=1 commits mem[wr_addr]<=wr_data at the edge.
  - With ZERO_REG=1, writes to address 0 are dropped silently; wr_ready is still 1.
- CLEAR:
  - busy=1 and wr_ready=0.
  - Each cycle mem[cnt]<=0 and cnt increments. The sweep starts at cnt=0 and runs DEPTH cycles.
  - Writes presented while wr_ready=0 are dropped. The producer must hold the write until wr_ready=1.
  - clr_req is ignored while in CLEAR.
- Same cycle in IDLE, we=1 and clr_req=1: the write commits, the sweep starts next cycle, and the sweep later zeroes the written entry.
- Reads:
  - Every port samples rd_addr each edge, in all states.
  - A read of address 0 with ZERO_REG=1 returns 0.
  - An address ≥ DEPTH returns 0.
  - Reads during CLEAR return current contents, so they may be partially cleared.
- Several ports reading the same address each return the same value.

## Timing
- Read latency is 1 cycle: rd_addr presented at edge t produces rd_data valid after edge t, stable until edge t+1.
- Write latency: data written at edge t is visible to a read addressed at edge t+1, i.e. on rd_data after t+1.
- Same-edge read and write to the same nonzero address: behaviour depends on REGFILE_BYPASS_EN (see Configuration).
- Clear sweep: clr_req seen at edge t makes busy=1 from t to t+DEPTH. busy falls, and wr_ready rises, after edge t+DEPTH.
- Reset mid-sweep: the sweep is abandoned and all entries are 0 in the next cycle.
- busy and wr_ready are registered outputs; no combinational path from inputs.

## Configuration
- REGFILE_BYPASS_EN defined:
  - An accepted write (we=1, wr_ready=1) whose address matches rd_addr of port k at the same edge forwards wr_data into rd_data[k].
  - The dropped-zero-register case is excluded; address 0 still reads 0.
- Not defined: the same-edge read returns the pre-write contents, and the new value appears on the following read.

## Structure
- Package reg_file_pkg:
  - state enum rf_state_t {RF_IDLE, RF_CLEAR}
  - default parameter constants (RF_DATA_W, RF_ADDR_W, RF_NUM_RD)
- Sub-module reg_file_clr_fsm:
  - Owns the state register, the sweep counter, busy and wr_ready.
  - Outputs clr_en and clr_addr to the storage array.
- Top level holds the storage array, the read ports (generate loop over NUM_RD) and the bypass mux.

## Test plan
- Reset:
  - Drive rst=0 for 2 cycles after random writes.
  - Every address read on all ports returns 0x00000000; busy=0 and wr_ready=1.
- Write/read:
  - Write 0xDEADBEEF to x5, then next cycle read x5 on ports 0 and 1.
  - Both rd_data show 0xDEADBEEF one cycle later.
  - Write 0x1234 to x0; a read of x0 returns 0.
- Bypass:
  - Same-edge write 0xA5A5A5A5 to x7 and read of x7, with x7 previously holding 0x11.
  - Returns 0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x11 without it.
- Clear sweep (DEPTH=32):
  - Fill all entries with 0xFFFFFFFF, pulse clr_req.
  - busy is high for exactly 32 cycles.
  - A write to x3 during the sweep sees wr_ready=0 and is dropped.
  - After busy falls, all reads return 0.
- Simultaneous write and clr_req:
  - Write 0x55 to x9 together with clr_req; x9 reads 0 after the sweep.
  - A second clr_req mid-sweep leaves the duration at 32 cycles.
- Reset mid-sweep:
  - Assert rst=0 at sweep cycle 10.
  - Next cycle busy=0, wr_ready=1, and all entries read 0.
